// File: rtl/pulse_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_rx_checker
//  Description : Receive-side checker for the single-line pulse protocol.
//                Measures every high run on din and flags it as legal,
//                short or long. Flags rising edges that arrive before the
//                required gap. Keeps a saturating count of legal pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_rx_checker #(
    parameter int PULSE_LEN = 3,
    parameter int GAP_LEN   = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             valid,
    output logic             err_short,
    output logic             err_long,
    output logic             err_gap,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             busy
);

    localparam int WCNT_W = $clog2(PULSE_LEN + 1);
    localparam int GCNT_W = $clog2(GAP_LEN + 1);

    localparam logic [WCNT_W-1:0] c_pulse_len = WCNT_W'(PULSE_LEN);
    localparam logic [WCNT_W-1:0] c_wcnt_one  = WCNT_W'(1);
    localparam logic [GCNT_W-1:0] c_gap_last  = GCNT_W'(GAP_LEN - 1);
    localparam logic [GCNT_W-1:0] c_gcnt_one  = GCNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
    // A single low sample already satisfies the gap: skip the GAP state.
    localparam bit                c_gap_one   = (GAP_LEN == 1);

    typedef enum logic [2:0] {
        S_SYNC     = 3'd0,
        S_IDLE     = 3'd1,
        S_HIGH     = 3'd2,
        S_GAP      = 3'd3,
        S_WAIT_LOW = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic [GCNT_W-1:0]   r_gcnt;
    logic [GCNT_W-1:0]   w_gcnt_nxt;
    logic [CNT_W-1:0]    r_pulse_cnt;
    logic [CNT_W-1:0]    w_pulse_cnt_nxt;
    logic                r_valid, r_err_short, r_err_long, r_err_gap, r_busy;
    logic                w_valid_nxt, w_err_short_nxt, w_err_long_nxt, w_err_gap_nxt;
    logic                w_busy_nxt;

    // Next-state, run/gap counters and strobe decisions from the current sample.
    always_comb begin
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_gcnt_nxt      = r_gcnt;
        w_valid_nxt     = 1'b0;
        w_err_short_nxt = 1'b0;
        w_err_long_nxt  = 1'b0;
        w_err_gap_nxt   = 1'b0;

        case (r_state)
            S_SYNC: begin
                // Wait out any pulse already in flight when reset was released.
                if (!din) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (din) begin
                    w_state_nxt = S_HIGH;
                    w_wcnt_nxt  = c_wcnt_one;
                end
            end
            S_HIGH: begin
                if (din) begin
                    if (r_wcnt == c_pulse_len) begin
                        w_err_long_nxt = 1'b1;
                        w_state_nxt    = S_WAIT_LOW;
                    end else begin
                        w_wcnt_nxt = r_wcnt + c_wcnt_one;
                    end
                end else begin
                    if (r_wcnt == c_pulse_len) begin
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_short_nxt = 1'b1;
                    end
                    // The falling sample is gap sample 1.
                    w_gcnt_nxt  = c_gcnt_one;
                    w_state_nxt = c_gap_one ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (din) begin
                    w_err_gap_nxt = 1'b1;
                    w_state_nxt   = S_WAIT_LOW;
                end else if (r_gcnt == c_gap_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt + c_gcnt_one;
                end
            end
            S_WAIT_LOW: begin
                // Unmeasured run: just wait for it to end, then time the gap.
                if (!din) begin
                    w_gcnt_nxt  = c_gcnt_one;
                    w_state_nxt = c_gap_one ? S_IDLE : S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_SYNC;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == S_GAP) ||
                     (w_state_nxt == S_WAIT_LOW);
    end

    // Saturating legal-pulse counter; a clear coinciding with a pulse leaves 1.
    always_comb begin
        w_pulse_cnt_nxt = r_pulse_cnt;
        if (w_valid_nxt) begin
            if (clr_cnt) begin
                w_pulse_cnt_nxt = c_cnt_one;
            end else if (r_pulse_cnt != c_cnt_max) begin
                w_pulse_cnt_nxt = r_pulse_cnt + c_cnt_one;
            end
        end else if (clr_cnt) begin
            w_pulse_cnt_nxt = '0;
        end
    end

    // State, counters and all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_SYNC;
            r_wcnt      <= '0;
            r_gcnt      <= '0;
            r_pulse_cnt <= '0;
            r_valid     <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_gap   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_err_short <= w_err_short_nxt;
            r_err_long  <= w_err_long_nxt;
            r_err_gap   <= w_err_gap_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign valid     = r_valid;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign err_gap   = r_err_gap;
    assign pulse_cnt = r_pulse_cnt;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pulse_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_rx_checker
//  Description : Self-checking bench for pulse_rx_checker. A run-length model
//                predicts every registered output each cycle; directed
//                sequences are also pinned with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_rx_checker;

    localparam int PULSE = 3;
    localparam int GAP   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       valid, err_short, err_long, err_gap, busy;
    logic [7:0] pulse_cnt;
    logic       valid2, err_short2, err_long2, err_gap2, busy2;
    logic [1:0] pulse_cnt2;

    int checks   = 0;
    int failures = 0;

    // Model state: run-length view of the line.
    bit m_synced;
    int m_highs;
    int m_lows;
    bit m_meas;
    int m_cnt8, m_cnt2;
    bit e_valid, e_short, e_long, e_gap, e_busy;

    // Strobes observed on the main DUT since the last tally clear.
    int n_valid, n_short, n_long, n_gap;

    pulse_rx_checker #(.PULSE_LEN(PULSE), .GAP_LEN(GAP), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .valid(valid), .err_short(err_short), .err_long(err_long),
        .err_gap(err_gap), .pulse_cnt(pulse_cnt), .busy(busy)
    );

    pulse_rx_checker #(.PULSE_LEN(PULSE), .GAP_LEN(GAP), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .valid(valid2), .err_short(err_short2), .err_long(err_long2),
        .err_gap(err_gap2), .pulse_cnt(pulse_cnt2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Predict register contents after the next edge from the sample rules.
    task automatic model(input bit d, input bit c, input bit rn);
        e_valid = 0; e_short = 0; e_long = 0; e_gap = 0;
        if (!rn) begin
            m_synced = 0; m_highs = 0; m_lows = 0; m_meas = 0;
            m_cnt8 = 0; m_cnt2 = 0; e_busy = 0;
            return;
        end
        if (!m_synced) begin
            if (!d) begin
                m_synced = 1;
                m_lows   = GAP;
            end
        end else if (d) begin
            if (m_highs == 0) begin
                m_meas = (m_lows >= GAP);
                e_gap  = !m_meas;
            end
            m_highs++;
            if (m_meas && m_highs == PULSE + 1) begin
                e_long = 1;
                m_meas = 0;
            end
        end else begin
            if (m_highs > 0) begin
                if (m_meas) begin
                    if (m_highs == PULSE) e_valid = 1;
                    else                  e_short = 1;
                end
                m_lows = 1;
            end else if (m_lows < GAP) begin
                m_lows++;
            end
            m_highs = 0;
            m_meas  = 0;
        end
        if (e_valid) begin
            m_cnt8 = c ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
            m_cnt2 = c ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
        end else if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end
        e_busy = m_synced && (m_highs > 0 || m_lows < GAP);
    endtask

    // Drive one sample, let one edge pass, compare both DUTs with the model.
    task automatic step(input bit d, input bit c, input bit rn);
        din = d; clr_cnt = c; rst_n = rn;
        model(d, c, rn);
        @(negedge clk);
        chk("valid",      valid,      e_valid);
        chk("err_short",  err_short,  e_short);
        chk("err_long",   err_long,   e_long);
        chk("err_gap",    err_gap,    e_gap);
        chk("busy",       busy,       e_busy);
        chk("pulse_cnt",  pulse_cnt,  m_cnt8);
        chk("valid2",     valid2,     e_valid);
        chk("err_gap2",   err_gap2,   e_gap);
        chk("err_short2", err_short2, e_short);
        chk("err_long2",  err_long2,  e_long);
        chk("busy2",      busy2,      e_busy);
        chk("pulse_cnt2", pulse_cnt2, m_cnt2);
        n_valid += int'(valid);
        n_short += int'(err_short);
        n_long  += int'(err_long);
        n_gap   += int'(err_gap);
    endtask

    task automatic tally_clear();
        n_valid = 0; n_short = 0; n_long = 0; n_gap = 0;
    endtask

    task automatic run(input bit d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0, 1'b1);
    endtask

    task automatic legal_pulse();
        run(1'b1, PULSE);
        run(1'b0, GAP);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);

        // Reset state
        do_reset();
        chk("reset_cnt",  pulse_cnt, 0);
        chk("reset_busy", busy, 0);

        // 1: basic legal pulse
        tally_clear();
        run(1'b0, 2);
        run(1'b1, 3);
        step(1'b0, 1'b0, 1'b1);
        chk("t1_valid_now", valid, 1);
        chk("t1_busy_gap",  busy, 1);
        run(1'b0, 2);
        chk("t1_busy_end",  busy, 0);
        chk("t1_nvalid",    n_valid, 1);
        chk("t1_cnt",       pulse_cnt, 1);

        // 2: short pulse
        tally_clear();
        run(1'b1, 2);
        run(1'b0, 3);
        chk("t2_nshort", n_short, 1);
        chk("t2_nvalid", n_valid, 0);
        chk("t2_cnt",    pulse_cnt, 1);

        // 3: long pulse
        tally_clear();
        run(1'b1, 4);
        chk("t3_long_now", err_long, 1);
        run(1'b1, 1);
        run(1'b0, 3);
        chk("t3_nlong",  n_long, 1);
        chk("t3_nother", n_valid + n_short + n_gap, 0);
        chk("t3_busy",   busy, 0);

        // 4a: gap violation after a legal pulse
        tally_clear();
        run(1'b1, 3);
        run(1'b0, 2);
        run(1'b1, 1);
        chk("t4a_gap_now", err_gap, 1);
        run(1'b1, 2);
        run(1'b0, 3);
        chk("t4a_nvalid", n_valid, 1);
        chk("t4a_ngap",   n_gap, 1);

        // 4b: two legal pulses with exact gap
        do_reset();
        tally_clear();
        run(1'b0, 1);
        legal_pulse();
        legal_pulse();
        chk("t4b_nvalid", n_valid, 2);
        chk("t4b_cnt",    pulse_cnt, 2);

        // 5: reset mid-pulse, released while din is high
        tally_clear();
        run(1'b1, 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        run(1'b1, 1);
        run(1'b0, 3);
        legal_pulse();
        chk("t5_nvalid", n_valid, 1);
        chk("t5_nerr",   n_short + n_long + n_gap, 0);
        chk("t5_cnt",    pulse_cnt, 1);

        // 6: saturation of the 2-bit counter, then clear on the valid edge
        do_reset();
        run(1'b0, 1);
        for (int i = 0; i < 5; i++) legal_pulse();
        chk("t6_sat2", pulse_cnt2, 3);
        chk("t6_cnt8", pulse_cnt, 5);
        run(1'b1, 3);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_clr2", pulse_cnt2, 1);
        chk("t6_clr8", pulse_cnt, 1);
        run(1'b0, 2);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_clr_alone", pulse_cnt, 0);

        // Randomized runs of highs and lows with occasional clears and resets
        for (int r = 0; r < 400; r++) begin
            int hl, ll;
            hl = $urandom_range(1, 5);
            ll = $urandom_range(1, 5);
            for (int i = 0; i < hl; i++)
                step(1'b1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
            for (int i = 0; i < ll; i++)
                step(1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
